// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between a data source and the
// sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  // Requester side: issues start/bin, observes status and result
  modport master (output start, bin, input busy, done, bcd, ovf);
  // Converter side
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one bit per clock.
// Result register is only written on entry to DONE, so the downstream
// digit decoder never sees partial values.
module bin2bcd_seq #(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_val(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] LIMIT = max_val(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic               sat_q, sat_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [SR_W-1:0]    adj;
  logic [SR_W-1:0]    shifted;
  logic               last_shift;

  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

  // State and datapath registers; reset aborts any conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      sat_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      sat_q   <= sat_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-nibble add-3 correction (no inter-nibble carry), then shift left
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5)
        adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
    end
    shifted = {adj[SR_W-2:0], 1'b0};
  end

  // Datapath next values: load on accept, shift in SHIFT, publish on last shift
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    sat_d = sat_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d  = {{BCD_W{1'b0}}, bus.bin};
          sat_d = (64'(bus.bin) > LIMIT);
          cnt_d = '0;
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_shift) begin
          bcd_d = sat_q ? {DIGITS{4'h9}} : shifted[SR_W-1 -: BCD_W];
          ovf_d = sat_q;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  assign bus.bcd = bcd_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: per-cycle scoreboard against a timing/
// arithmetic reference, plus literal checks on each scenario.
module tb_bin2bcd_seq;
  localparam int BIN_W  = 17;
  localparam int DIGITS = 5;
  localparam int LAT    = BIN_W + 1;   // accept -> done
  localparam int PERIOD = BIN_W + 2;   // accept -> next possible accept

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus_if ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion by decimal division
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    r = '0;
    if (v > 99999) return 20'h99999;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Model: m_cnt = cycles since accept (0 = idle)
  int          m_cnt;
  logic [19:0] m_pend, m_bcd;
  logic        m_povf, m_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_bcd <= '0; m_ovf <= 1'b0;
    end else if (m_cnt == 0) begin
      if (bus_if.start) begin
        m_cnt  <= 1;
        m_pend <= ref_bcd(int'(bus_if.bin));
        m_povf <= (int'(bus_if.bin) > 99999);
      end
    end else if (m_cnt == LAT) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1) begin
        m_bcd <= m_pend;
        m_ovf <= m_povf;
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus_if.busy), 32'(m_cnt != 0));
      chk("done", 32'(bus_if.done), 32'(m_cnt == LAT));
      chk("bcd",  32'(bus_if.bcd),  32'(m_bcd));
      chk("ovf",  32'(bus_if.ovf),  32'(m_ovf));
    end
  end

  // Pulse start for one cycle; returns after the accept edge (first negedge = cycle 1)
  task automatic pulse(input int v);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.bin   = 17'(v);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.bin   = '0;
  endtask

  // From cycle cyc, wait for done (bounded) and check latency and result literals
  task automatic wait_done(input string name, input int cyc, input logic [19:0] eb, input logic eo);
    int c;
    c = cyc;
    while (!bus_if.done && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_lat"}, 32'(c), 32'(LAT));
    chk({name, "_bcd"}, 32'(bus_if.bcd), 32'(eb));
    chk({name, "_ovf"}, 32'(bus_if.ovf), 32'(eo));
    @(negedge clk);
    chk({name, "_idle"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.bin   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_bcd",  32'(bus_if.bcd),  32'h0);
    chk("rst_ovf",  32'(bus_if.ovf),  32'h0);
    chk("rst_busy", 32'(bus_if.busy), 32'h0);
    chk("rst_done", 32'(bus_if.done), 32'h0);
    repeat (50) @(negedge clk);
    chk("quiet_bcd", 32'(bus_if.bcd), 32'h0);

    // Basic conversion; bcd must stay 0 through SHIFT
    pulse(12345);
    for (int c = 1; c < LAT; c++) begin
      chk("shift_hold", 32'(bus_if.bcd), 32'h0);
      @(negedge clk);
    end
    wait_done("basic", LAT, 20'h12345, 1'b0);

    // Boundaries
    pulse(0);      wait_done("zero",   1, 20'h00000, 1'b0);
    pulse(99999);  wait_done("max",    1, 20'h99999, 1'b0);
    pulse(100000); wait_done("sat",    1, 20'h99999, 1'b1);
    pulse(131071); wait_done("allone", 1, 20'h99999, 1'b1);
    pulse(7);      wait_done("seven",  1, 20'h00007, 1'b0);

    // Ignored start during SHIFT and DONE
    pulse(500);
    for (int c = 1; c <= PERIOD; c++) begin
      if (c == 5 || c == 17 || c == 18) begin
        bus_if.start = 1'b1; bus_if.bin = 17'd777;
      end else begin
        bus_if.start = 1'b0; bus_if.bin = '0;
      end
      if (c == LAT) begin
        chk("ign_done", 32'(bus_if.done), 32'd1);
        chk("ign_bcd",  32'(bus_if.bcd),  32'h00500);
      end
      if (c == PERIOD) chk("ign_busy", 32'(bus_if.busy), 32'd0);
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    repeat (25) @(negedge clk);
    chk("ign_bcd_after", 32'(bus_if.bcd), 32'h00500);

    // Back-to-back with start held high
    bus_if.start = 1'b1;
    bus_if.bin   = 17'd11111;
    @(negedge clk);
    bus_if.bin   = 17'd22222;
    for (int c = 1; c <= PERIOD + LAT; c++) begin
      if (c == LAT) begin
        chk("b2b_done1", 32'(bus_if.done), 32'd1);
        chk("b2b_bcd1",  32'(bus_if.bcd),  32'h11111);
      end
      if (c == PERIOD + 1) bus_if.start = 1'b0;
      if (c == PERIOD + LAT) begin
        chk("b2b_done2", 32'(bus_if.done), 32'd1);
        chk("b2b_bcd2",  32'(bus_if.bcd),  32'h22222);
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Reset mid-conversion, then recover
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse(54321);
    for (int c = 1; c < 9; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    chk("abort_done", 32'(bus_if.done), 32'd0);
    chk("abort_bcd",  32'(bus_if.bcd),  32'h0);
    repeat (25) @(negedge clk);
    chk("abort_nodone_bcd", 32'(bus_if.bcd), 32'h0);
    pulse(54321);
    wait_done("recover", 1, 20'h54321, 1'b0);

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
